fft_reorder_buffer: RTL and testbench



---
 rtl/fft_reorder_buffer.sv | 156 +++++++++++++++
 tb/tb_fft_reorder_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_buffer
// Description : Sink-side reorder buffer for the radix-2^2 SDF FFT pipeline.
//               Takes the bit-reversed sample stream from the last SDF stage.
//               Re-emits each N-point frame in natural order.
//               Two banks are used ping-pong style: frame k+1 is written into
//               one bank while frame k is read from the other. This sustains
//               one sample per clock with no stalls.
//
// Ports       : clock               - system clock, rising edge
//               reset               - asynchronous active-high reset
//               data_input_en       - input sample valid (N cycles per frame)
//               data_input_real     - input real part, bit-reversed order
//               data_input_complex  - input imaginary part, bit-reversed order
//               data_output_en      - output sample valid
//               data_output_real    - output real part, natural order
//               data_output_complex - output imaginary part, natural order
//               data_output_last    - high with output sample index N-1
//               frame_abort         - one-cycle pulse on partial-frame discard
//
// Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_buffer #(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_input_en,
    input  logic [WIDTH-1:0] data_input_real,
    input  logic [WIDTH-1:0] data_input_complex,
    output logic             data_output_en,
    output logic [WIDTH-1:0] data_output_real,
    output logic [WIDTH-1:0] data_output_complex,
    output logic             data_output_last,
    output logic             frame_abort
);

    localparam int               LOG_N       = $clog2(N);
    localparam logic [LOG_N-1:0] C_LAST_IDX  = LOG_N'(N - 1);
    localparam logic [LOG_N-1:0] C_ONE       = LOG_N'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    // Sample storage: {bank, address} indexes a 2N-deep array of {re, im}.
    logic [2*WIDTH-1:0] r_mem [0:2*N-1];

    logic [LOG_N-1:0] r_wr_count;
    logic             r_wr_bank;
    logic [LOG_N-1:0] w_wr_addr;
    logic             r_frame_done;
    logic             r_filled_bank;

    state_t           r_state;
    logic [LOG_N-1:0] r_rd_count;
    logic             r_rd_bank;

    // Write address is the bit-reversed input index. After this, a linear
    // read sweep yields natural order.
    generate
        for (genvar gi = 0; gi < LOG_N; gi++) begin : g_bitrev
            assign w_wr_addr[gi] = r_wr_count[LOG_N-1-gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (data_input_en) begin
            r_mem[{r_wr_bank, w_wr_addr}] <= {data_input_real, data_input_complex};
        end
    end

    // Write-side control. The frame-complete trigger is registered.
    // The read side therefore starts one cycle after the last sample lands.
    // This gives the two-clock input-to-output latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_count    <= '0;
            r_wr_bank     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_filled_bank <= 1'b0;
            frame_abort   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            frame_abort  <= 1'b0;
            if (data_input_en) begin
                if (r_wr_count == C_LAST_IDX) begin
                    r_wr_count    <= '0;
                    r_wr_bank     <= ~r_wr_bank;
                    r_frame_done  <= 1'b1;
                    r_filled_bank <= r_wr_bank;
                end else begin
                    r_wr_count <= r_wr_count + C_ONE;
                end
            end else if (r_wr_count != '0) begin
                // Valid dropped mid-frame: discard the partial frame.
                // Refill the same bank from index 0.
                r_wr_count  <= '0;
                frame_abort <= 1'b1;
            end
        end
    end

    // Read FSM with the registered output stage. Triggers are at least N
    // cycles apart. Each one therefore arrives no earlier than the final read
    // cycle of the previous frame. That is the only place a back-to-back
    // restart needs to be handled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state             <= ST_IDLE;
            r_rd_count          <= '0;
            r_rd_bank           <= 1'b0;
            data_output_en      <= 1'b0;
            data_output_last    <= 1'b0;
            data_output_real    <= '0;
            data_output_complex <= '0;
        end else begin
            data_output_en   <= (r_state == ST_READ);
            data_output_last <= (r_state == ST_READ) && (r_rd_count == C_LAST_IDX);
            if (r_state == ST_READ) begin
                {data_output_real, data_output_complex} <= r_mem[{r_rd_bank, r_rd_count}];
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_frame_done) begin
                        r_state    <= ST_READ;
                        r_rd_bank  <= r_filled_bank;
                        r_rd_count <= '0;
                    end
                end
                ST_READ: begin
                    if (r_rd_count == C_LAST_IDX) begin
                        r_rd_count <= '0;
                        if (r_frame_done) begin
                            r_rd_bank <= r_filled_bank;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_rd_count <= r_rd_count + C_ONE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rd_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_reorder_buffer
// Description : Self-checking bench for fft_reorder_buffer.
//               Exercises an N=64/WIDTH=16 instance and an N=4/WIDTH=8 instance.
//               Expected natural-order samples are queued as frames are driven.
//               They are compared as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_reorder_buffer;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } exp_t;

    typedef struct {
        logic [7:0] in_re;
        logic [7:0] in_im;
        logic [7:0] exp_re;
        logic [7:0] exp_im;
        logic       exp_last;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=64 instance
    logic        rst64, en64;
    logic [15:0] re64, im64;
    logic        oen64, olast64, abort64;
    logic [15:0] ore64, oim64;

    // N=4 instance
    logic        rst4, en4;
    logic [7:0]  re4, im4;
    logic        oen4, olast4, abort4;
    logic [7:0]  ore4, oim4;

    fft_reorder_buffer #(.N(64), .WIDTH(16)) dut64 (
        .clock               (clk),
        .reset               (rst64),
        .data_input_en       (en64),
        .data_input_real     (re64),
        .data_input_complex  (im64),
        .data_output_en      (oen64),
        .data_output_real    (ore64),
        .data_output_complex (oim64),
        .data_output_last    (olast64),
        .frame_abort         (abort64)
    );

    fft_reorder_buffer #(.N(4), .WIDTH(8)) dut4 (
        .clock               (clk),
        .reset               (rst4),
        .data_input_en       (en4),
        .data_input_real     (re4),
        .data_input_complex  (im4),
        .data_output_en      (oen4),
        .data_output_real    (ore4),
        .data_output_complex (oim4),
        .data_output_last    (olast4),
        .frame_abort         (abort4)
    );

    int   vectors = 0;
    int   fails   = 0;
    exp_t q64[$];
    exp_t q4[$];
    int   run64 = 0, last_run64 = 0, abort_cnt = 0;
    int   run4 = 0, last_run4 = 0;
    exp_t e64, e4;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic int br(input int v, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++)
            if (v[b]) r |= (1 << (bits - 1 - b));
        return r;
    endfunction

    // Output monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (oen64) begin
            run64++;
            if (q64.size() == 0) begin
                chk("spurious_out64", 32'(oen64), 32'd0);
            end else begin
                e64 = q64.pop_front();
                chk("real64", 32'(ore64), 32'(e64.re));
                chk("cplx64", 32'(oim64), 32'(e64.im));
                chk("last64", 32'(olast64), 32'(e64.last));
            end
        end else begin
            if (run64 > 0) last_run64 = run64;
            run64 = 0;
            if (olast64) chk("last_idle64", 32'(olast64), 32'd0);
        end
        if (abort64) abort_cnt++;
    end

    always @(negedge clk) begin
        if (oen4) begin
            run4++;
            if (q4.size() == 0) begin
                chk("spurious_out4", 32'(oen4), 32'd0);
            end else begin
                e4 = q4.pop_front();
                chk("real4", 32'(ore4), 32'(e4.re[7:0]));
                chk("cplx4", 32'(oim4), 32'(e4.im[7:0]));
                chk("last4", 32'(olast4), 32'(e4.last));
            end
        end else begin
            if (run4 > 0) last_run4 = run4;
            run4 = 0;
        end
    end

    task automatic drive64(input logic [15:0] r, input logic [15:0] i);
        en64 = 1'b1;
        re64 = r;
        im64 = i;
        @(posedge clk);
        #1;
    endtask

    // Drive one full frame with real = base+k, complex = -(base+k).
    // Optionally queue its natural-order expectation.
    task automatic frame64(input int base, input bit push);
        logic [15:0] vr [64];
        for (int k = 0; k < 64; k++) begin
            vr[k] = 16'(base + k);
            drive64(vr[k], 16'd0 - vr[k]);
        end
        if (push) begin
            for (int p = 0; p < 64; p++) begin
                q64.push_back('{re: vr[br(p, 6)], im: 16'd0 - vr[br(p, 6)], last: (p == 63)});
            end
        end
    endtask

    task automatic drain64();
        for (int i = 0; i < 400 && q64.size() != 0; i++) @(posedge clk);
        chk("drain64", 32'(q64.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain4();
        for (int i = 0; i < 100 && q4.size() != 0; i++) @(posedge clk);
        chk("drain4", 32'(q4.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [4];
        logic [7:0]  rv  [4];
        logic [7:0]  iv  [4];

        rst64 = 1'b1; rst4 = 1'b1;
        en64 = 1'b0; re64 = '0; im64 = '0;
        en4  = 1'b0; re4  = '0; im4  = '0;

        // Reset state
        #12;
        chk("rst_en64",    32'(oen64),   32'd0);
        chk("rst_last64",  32'(olast64), 32'd0);
        chk("rst_re64",    32'(ore64),   32'd0);
        chk("rst_im64",    32'(oim64),   32'd0);
        chk("rst_abort64", 32'(abort64), 32'd0);
        chk("rst_en4",     32'(oen4),    32'd0);
        chk("rst_last4",   32'(olast4),  32'd0);
        chk("rst_re4",     32'(ore4),    32'd0);
        chk("rst_abort4",  32'(abort4),  32'd0);
        @(posedge clk); #1;
        rst64 = 1'b0; rst4 = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Single frame: latency of exactly two clocks, 64-cycle burst
        frame64(0, 1'b1);
        en64 = 1'b0;
        @(posedge clk); #1;
        chk("lat_early", 32'(oen64), 32'd0);
        @(posedge clk); #1;
        chk("lat_first", 32'(oen64), 32'd1);
        chk("lat_first_re", 32'(ore64), 32'd0);
        @(posedge clk); #1;
        chk("pos1_re", 32'(ore64), 32'd32);
        @(posedge clk); #1;
        chk("pos2_re", 32'(ore64), 32'd16);
        drain64();
        chk("run_single", 32'(last_run64), 32'd64);

        // Three frames back to back: one contiguous 192-cycle output burst
        frame64(100, 1'b1);
        frame64(200, 1'b1);
        frame64(300, 1'b1);
        en64 = 1'b0;
        drain64();
        chk("run_b2b", 32'(last_run64), 32'd192);

        // Abort: 20 samples, 5 idle, then a full frame
        chk("abort_none", 32'(abort_cnt), 32'd0);
        for (int k = 0; k < 20; k++) drive64(16'(1000 + k), 16'(2000 + k));
        en64 = 1'b0;
        @(posedge clk); #1;
        chk("abort_pulse", 32'(abort64), 32'd1);
        @(posedge clk); #1;
        chk("abort_width", 32'(abort64), 32'd0);
        repeat (3) @(posedge clk); #1;
        frame64(500, 1'b1);
        en64 = 1'b0;
        drain64();
        chk("abort_count", 32'(abort_cnt), 32'd1);
        chk("run_abort", 32'(last_run64), 32'd64);

        // Reset in the middle of an output burst and an input frame
        frame64(2000, 1'b1);
        for (int k = 0; k < 31; k++) drive64(16'(3000 + k), 16'(4000 + k));
        en64 = 1'b0;
        chk("pre_reset_active", 32'(oen64), 32'd1);
        #1;
        rst64 = 1'b1;
        q64.delete();
        #1;
        chk("mid_rst_en",   32'(oen64),   32'd0);
        chk("mid_rst_last", 32'(olast64), 32'd0);
        chk("mid_rst_re",   32'(ore64),   32'd0);
        chk("mid_rst_im",   32'(oim64),   32'd0);
        repeat (3) @(posedge clk); #1;
        rst64 = 1'b0;
        repeat (80) @(posedge clk); #1;
        chk("idle_after_reset", 32'(oen64), 32'd0);
        frame64(4000, 1'b1);
        en64 = 1'b0;
        drain64();
        chk("run_post_reset", 32'(last_run64), 32'd64);

        // N=4, WIDTH=8 table: bit-exact extremes, order is bitrev2
        tbl[0] = '{in_re: 8'h7F, in_im: 8'h80, exp_re: 8'h7F, exp_im: 8'h80, exp_last: 1'b0};
        tbl[1] = '{in_re: 8'h80, in_im: 8'h7F, exp_re: 8'h01, exp_im: 8'hFE, exp_last: 1'b0};
        tbl[2] = '{in_re: 8'h01, in_im: 8'hFE, exp_re: 8'h80, exp_im: 8'h7F, exp_last: 1'b0};
        tbl[3] = '{in_re: 8'hFF, in_im: 8'h00, exp_re: 8'hFF, exp_im: 8'h00, exp_last: 1'b1};
        for (int i = 0; i < 4; i++) begin
            en4 = 1'b1;
            re4 = tbl[i].in_re;
            im4 = tbl[i].in_im;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++)
            q4.push_back('{re: {8'd0, tbl[i].exp_re}, im: {8'd0, tbl[i].exp_im}, last: tbl[i].exp_last});
        en4 = 1'b0;
        drain4();
        chk("run4_table", 32'(last_run4), 32'd4);

        // N=4 random frame, reordered by the bench model
        for (int i = 0; i < 4; i++) begin
            rv[i] = 8'($urandom_range(0, 255));
            iv[i] = 8'($urandom_range(0, 255));
            en4 = 1'b1;
            re4 = rv[i];
            im4 = iv[i];
            @(posedge clk); #1;
        end
        for (int p = 0; p < 4; p++)
            q4.push_back('{re: {8'd0, rv[br(p, 2)]}, im: {8'd0, iv[br(p, 2)]}, last: (p == 3)});
        en4 = 1'b0;
        drain4();
        chk("run4_random", 32'(last_run4), 32'd4);
        chk("abort4_none", 32'(abort4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
